// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with a register-array store, binary
// read/write pointers, a separate occupancy counter, full/empty and
// programmable almost-full/almost-empty flags, a registered read port,
// sticky overflow/underflow error flags and a synchronous flush.
// Intended for same-domain buffering between the UART, ALU and register-file
// datapaths, so no clock-domain-crossing logic is present.

module sync_fifo_ctrl #(
    parameter int DSIZE     = 8,
    parameter int ADDR_SIZE = 3,
    parameter int AF_LEVEL  = 6,
    parameter int AE_LEVEL  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 clr_err,
    input  logic                 winc,
    input  logic [DSIZE-1:0]     wdata,
    input  logic                 rinc,
    output logic [DSIZE-1:0]     rdata,
    output logic                 rvalid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam int CW    = ADDR_SIZE + 1;

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_THRESH  = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_THRESH  = CW'(AE_LEVEL);

    // Storage array; deliberately has no reset so it maps onto plain registers.
    logic [DSIZE-1:0] mem [DEPTH];

    logic [ADDR_SIZE-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_SIZE-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DSIZE-1:0]     rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;

    logic                 fullFlag;
    logic                 emptyFlag;
    logic                 wrOk;
    logic                 rdOk;
    logic                 ovfEvent;
    logic                 udfEvent;

    // Status flags are pure decodes of the registered count so that no
    // request input ever reaches a flag combinationally.
    always_comb begin
        fullFlag     = (count_q == COUNT_FULL);
        emptyFlag    = (count_q == '0);
        almost_full  = (count_q >= AF_THRESH);
        almost_empty = (count_q <= AE_THRESH);
    end

    // Request qualification: flush overrides both requests, and a request
    // against a full/empty FIFO is rejected and reported as an error event.
    always_comb begin
        wrOk     = winc & ~fullFlag  & ~flush;
        rdOk     = rinc & ~emptyFlag & ~flush;
        ovfEvent = winc &  fullFlag  & ~flush;
        udfEvent = rinc &  emptyFlag & ~flush;
    end

    // Next-state computation for pointers, occupancy, read port and errors.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (wrOk) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (rdOk) begin
                rdPtr_d  = rdPtr_q + 1'b1;
                rdata_d  = mem[rdPtr_q];
                rvalid_d = 1'b1;
            end
            if (wrOk && !rdOk) begin
                count_d = count_q + 1'b1;
            end else if (rdOk && !wrOk) begin
                count_d = count_q - 1'b1;
            end
        end

        // A new error event wins over a clear requested in the same cycle.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (ovfEvent) begin
            overflow_d = 1'b1;
        end
        if (udfEvent) begin
            underflow_d = 1'b1;
        end
    end

    // Control and read-port registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write; only accepted writes touch the array, and a write
    // coinciding with reset is dropped because its pointer is being cleared.
    always_ff @(posedge clk) begin
        if (wrOk && !rst) begin
            mem[wrPtr_q] <= wdata;
        end
    end

    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign full      = fullFlag;
    assign empty     = emptyFlag;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
